puf_resp_uart_tx: RTL and testbench

- Consumer end of the PUF response path. Accepts one 64-bit response per valid/ready handshake and serialises it as a framed UART 8N1 byte stream for an off-chip host.
- Sits beside the PUF top level and runs in the same clk_ref domain.
- Frame layout: one SYNC byte, then 8 response bytes. The least-significant byte (bits [7:0]) goes first; within each character the LSB goes first.

---
 rtl/puf_tx_pkg.sv | 24 ++
 rtl/puf_resp_uart_tx_if.sv | 11 +
 rtl/uart_tx_byte.sv | 80 ++++++++
 rtl/puf_resp_uart_tx.sv | 113 +++++++++++
 tb/tb_puf_resp_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_tx_pkg.sv
// Shared types and helpers for the PUF response UART transmitter.
package puf_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // CRC-8, MSB-first, non-reflected, no final XOR; one byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/puf_resp_uart_tx_if.sv
// Response handshake bundle: producer drives valid/data, transmitter returns ready.
interface puf_resp_uart_tx_if #(
  parameter int RESP_W = 64
);
  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] resp_data;

  modport master (output resp_valid, output resp_data, input resp_ready);
  modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// Single-character 8N1 serialiser: start pulse begins a character, data is sampled at the end of the start bit.
// A start pulse coinciding with done chains the next character with no idle gap.
module uart_tx_byte
  import puf_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_ref,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       load,
  output logic       done,
  output logic       busy,
  output logic       txd
);
  localparam int            CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          tc;

  assign tc   = (cnt == TC);
  assign busy = (state != IDLE);
  assign load = (state == START) && tc;
  assign done = (state == STOP) && tc;
  assign txd  = (state == START) ? 1'b0 :
                (state == DATA)  ? shreg[0] : 1'b1;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = '0;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    if (state != IDLE && !tc) begin
      cnt_nx = cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        if (start) state_nx = START;
      end
      START: begin
        if (tc) begin
          shreg_nx   = data;
          bit_idx_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (tc) begin
          shreg_nx = shreg >> 1;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (tc) state_nx = start ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// Frames a captured PUF response as SYNC + LSB-first bytes (+ CRC-8 when PUF_TX_CRC8_EN) over UART 8N1.
// Start bit 1 cycle after acceptance; resp_ready stays low for the whole frame, valid while busy is ignored.
module puf_resp_uart_tx
  import puf_tx_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 100_000_000,
  parameter int         BAUD        = 115_200,
  parameter int         RESP_W      = 64,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  puf_resp_uart_tx_if.slave resp,
  output logic              uart_tx,
  output logic              busy
);
  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int NB           = RESP_W / 8;
`ifdef PUF_TX_CRC8_EN
  localparam int LAST         = NB + 1;
`else
  localparam int LAST         = NB;
`endif
  localparam int            IW     = $clog2(NB + 2);
  localparam logic [IW-1:0] LAST_I = IW'(LAST);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (RESP_W % 8 != 0) begin : g_bad_width
    $error("RESP_W must be a multiple of 8");
  end

  logic              active;
  logic [IW-1:0]     index;
  logic [IW-1:0]     idx_m1;
  logic [RESP_W-1:0] hold;
  logic              accept, more;
  logic              ser_start, ser_load, ser_done, ser_busy;
  logic [7:0]        ser_data, resp_byte;

  assign resp.resp_ready = !active && !ser_busy;
  assign accept          = resp.resp_valid && resp.resp_ready;
  assign more            = (index < LAST_I);
  // Next character is requested on the stop bit's final cycle so characters abut.
  assign ser_start       = accept || (ser_done && more);
  assign idx_m1          = index - 1'b1;
  assign busy            = active;

  always_comb begin
    resp_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_m1 == IW'(i)) resp_byte = hold[8*i +: 8];
    end
  end

`ifdef PUF_TX_CRC8_EN
  logic [7:0] crc;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (accept) begin
      crc <= '0;
    end else if (ser_load && index != '0 && index <= IW'(NB)) begin
      crc <= crc8_update(crc, resp_byte);
    end
  end

  always_comb begin
    ser_data = resp_byte;
    if (index == '0)         ser_data = SYNC_BYTE;
    else if (index == LAST_I) ser_data = crc;
  end
`else
  logic unused_load;
  assign unused_load = ser_load;

  always_comb begin
    ser_data = resp_byte;
    if (index == '0) ser_data = SYNC_BYTE;
  end
`endif

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      index  <= '0;
      hold   <= '0;
    end else if (accept) begin
      active <= 1'b1;
      index  <= '0;
      hold   <= resp.resp_data;
    end else if (ser_done) begin
      if (more) index  <= index + 1'b1;
      else      active <= 1'b0;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .start   (ser_start),
    .data    (ser_data),
    .load    (ser_load),
    .done    (ser_done),
    .busy    (ser_busy),
    .txd     (uart_tx)
  );

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// Bench for puf_resp_uart_tx: per-cycle waveform model, UART decoder and randomized valid/data traffic.
module tb_puf_resp_uart_tx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD_R = 100_000;
  localparam int CPB    = 10;
  localparam int RW     = 64;
  localparam int NB     = RW / 8;
`ifdef PUF_TX_CRC8_EN
  localparam int NCH    = NB + 2;
`else
  localparam int NCH    = NB + 1;
`endif
  localparam int FLEN   = NCH * 10 * CPB;

  logic clk_ref = 1'b0;
  logic rst_n   = 1'b1;
  logic uart_tx, busy;

  puf_resp_uart_tx_if #(.RESP_W(RW)) resp ();

  puf_resp_uart_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .RESP_W     (RW),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk_ref(clk_ref),
    .rst_n  (rst_n),
    .resp   (resp),
    .uart_tx(uart_tx),
    .busy   (busy)
  );

  always #5 clk_ref = ~clk_ref;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC-8 over the response bytes, LSB byte first, each byte MSB first.
  function automatic logic [7:0] crc_ref(input logic [63:0] r);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int b = 0; b < NB; b++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ r[8*b + i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] char_byte(input logic [63:0] r, input int ch);
    logic [63:0] s;
    if (ch == 0) return 8'hA5;
    if (ch > NB) return crc_ref(r);
    s = r >> (8 * (ch - 1));
    return s[7:0];
  endfunction

  // Line level kk cycles after acceptance (kk==0 means idle).
  function automatic logic exp_tx(input int kk, input logic [63:0] r);
    int         idx, ch, bp;
    logic [7:0] b;
    if (kk == 0) return 1'b1;
    idx = kk - 1;
    ch  = idx / (10 * CPB);
    bp  = (idx % (10 * CPB)) / CPB;
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    b = char_byte(r, ch);
    return b[bp-1];
  endfunction

  int          k      = 0;
  logic [63:0] m_resp = '0;

  always @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
    end else if (k == 0) begin
      if (resp.resp_valid === 1'b1) begin
        k      <= 1;
        m_resp <= resp.resp_data;
      end
    end else if (k == FLEN) begin
      k <= 0;
    end else begin
      k <= k + 1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk_ref) begin
    if (cmp_en) begin
      chk("tx_wave", uart_tx, exp_tx(k, m_resp));
      chk("busy_wave", busy, k != 0);
      chk("ready_wave", resp.resp_ready, k == 0);
    end
  end

  int busy_run = 0;
  int busy_len = 0;
  always @(negedge clk_ref) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  logic [7:0] dec [NCH];
  logic [7:0] lit1 [9];

  task automatic decode_frame();
    int w;
    for (int c = 0; c < NCH; c++) begin
      w = 0;
      while (uart_tx !== 1'b0 && w < 3000) begin
        @(negedge clk_ref);
        w++;
      end
      if (w >= 3000) begin
        total++;
        bad++;
        $display("FAIL start_timeout: char %0d line %b after %0d cycles", c, uart_tx, w);
        return;
      end
      repeat (CPB / 2) @(negedge clk_ref);
      chk("start_bit", uart_tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk_ref);
        dec[c][i] = uart_tx;
      end
      repeat (CPB) @(negedge clk_ref);
      chk("stop_bit", uart_tx, 1'b1);
    end
  endtask

  task automatic chk_frame(input string name, input logic [63:0] r);
    for (int c = 0; c < NCH; c++) chk(name, dec[c], char_byte(r, c));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 3000) begin
      @(negedge clk_ref);
      w++;
    end
    if (w >= 3000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy %b after %0d cycles", busy, w);
    end
    @(negedge clk_ref);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (resp.resp_ready !== 1'b1 && w < 3000) begin
      @(negedge clk_ref);
      w++;
    end
    if (w >= 3000) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ready %b after %0d cycles", resp.resp_ready, w);
    end
  endtask

  task automatic send_one(input logic [63:0] d);
    wait_ready();
    resp.resp_valid = 1'b1;
    resp.resp_data  = d;
    @(negedge clk_ref);
    resp.resp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    lit1 = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    resp.resp_valid = 1'b0;
    resp.resp_data  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_ref);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_ready", resp.resp_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    repeat (1000) @(negedge clk_ref);
    chk("idle_tx", uart_tx, 1'b1);
    chk("idle_ready", resp.resp_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Single one-cycle-valid frame with the reference pattern.
    send_one(64'h0123_4567_89AB_CDEF);
    chk("start_latency", uart_tx, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
    decode_frame();
    for (int c = 0; c < 9; c++) chk("lit_frame", dec[c], lit1[c]);
`ifdef PUF_TX_CRC8_EN
    chk("crc_byte", dec[NB+1], crc_ref(64'h0123_4567_89AB_CDEF));
`endif
    wait_idle();
`ifdef PUF_TX_CRC8_EN
    chk("busy_len", busy_len, 1000);
`else
    chk("busy_len", busy_len, 900);
`endif

    // Valid held through the frame while data changes underneath.
    wait_ready();
    resp.resp_valid = 1'b1;
    resp.resp_data  = 64'h1122_3344_5566_7788;
    @(negedge clk_ref);
    resp.resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
    decode_frame();
    chk_frame("held_first", 64'h1122_3344_5566_7788);
    wait_ready();
    chk("held_not_yet", busy, 1'b0);
    @(negedge clk_ref);
    chk("held_accept", busy, 1'b1);
    resp.resp_valid = 1'b0;
    decode_frame();
    chk_frame("held_second", 64'hDEAD_BEEF_CAFE_F00D);
    wait_idle();

    // Reset 350 cycles into an all-zero frame, where a zero data bit is on the line.
    send_one(64'h0);
    repeat (349) @(negedge clk_ref);
    chk("pre_reset_tx", uart_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx", uart_tx, 1'b1);
    chk("reset_ready", resp.resp_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    repeat (5) @(negedge clk_ref);
    #2 rst_n = 1'b1;
    @(negedge clk_ref);
    send_one(64'hFFFF_FFFF_FFFF_FFFF);
    decode_frame();
    chk("ff_sync", dec[0], 8'hA5);
    for (int c = 1; c <= NB; c++) chk("ff_byte", dec[c], 8'hFF);
`ifdef PUF_TX_CRC8_EN
    chk("ff_crc", dec[NB+1], crc_ref(64'hFFFF_FFFF_FFFF_FFFF));
`endif
    wait_idle();

    // All-zero response, full frame.
    send_one(64'h0);
    decode_frame();
    chk("zero_sync", dec[0], 8'hA5);
    for (int c = 1; c < NCH; c++) chk("zero_byte", dec[c], 8'h00);
    wait_idle();
`ifdef PUF_TX_CRC8_EN
    chk("zero_busy_len", busy_len, 1000);
`else
    chk("zero_busy_len", busy_len, 900);
`endif

    // Random valid pulses and data, including during busy; the waveform model judges every cycle.
    for (int n = 0; n < 6000; n++) begin
      resp.resp_valid = ($urandom_range(0, 99) < 3);
      resp.resp_data  = {$urandom, $urandom};
      @(negedge clk_ref);
    end
    resp.resp_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk_ref);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
